// File: rtl/cache_refill_if.sv
// cache_refill_if: miss/fill handshake and main-memory block bus of the refill unit.
// slave is the refill unit's side; master is the cache plus backing memory.
interface cache_refill_if #(
   parameter int BLOCK_SIZE = 32,
   parameter int NUM_OF_BLOCKS_PER_LINE = 4,
   parameter int ADDRESS_SIZE = 32
);
   localparam int LINE_BITS = BLOCK_SIZE * NUM_OF_BLOCKS_PER_LINE;
   logic miss_valid, miss_ready, evict_dirty;
   logic [ADDRESS_SIZE-1:0] miss_addr, evict_addr, fill_addr, mem_addr;
   logic [LINE_BITS-1:0] evict_data, fill_data;
   logic fill_valid, mem_req, mem_we, mem_ack;
   logic [BLOCK_SIZE-1:0] mem_wdata, mem_rdata;
   modport slave (
      input miss_valid, miss_addr, evict_dirty, evict_addr, evict_data, mem_ack, mem_rdata,
      output miss_ready, fill_valid, fill_addr, fill_data, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output miss_valid, miss_addr, evict_dirty, evict_addr, evict_data, mem_ack, mem_rdata,
      input miss_ready, fill_valid, fill_addr, fill_data, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_refill_unit.sv
// cache_refill_unit: dirty-victim writeback then block-by-block line fetch for the direct-mapped cache.
// Optional CACHE_REFILL_CRITICAL_FIRST_EN: fetch starts at the missing block's offset and wraps.
module cache_refill_unit #(
   parameter int BLOCK_SIZE = 32,
   parameter int NUM_OF_BLOCKS_PER_LINE = 4,
   parameter int ADDRESS_SIZE = 32,
   parameter int OFFSET_LENGTH = $clog2(NUM_OF_BLOCKS_PER_LINE),
   parameter int LINE_BITS = BLOCK_SIZE * NUM_OF_BLOCKS_PER_LINE
) (
   input logic clk,
   input logic rst,
   cache_refill_if.slave bus
);
   localparam int LW = ADDRESS_SIZE - OFFSET_LENGTH;
   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
   typedef logic [OFFSET_LENGTH-1:0] off_t;
   state_t state, state_n;
   off_t k, k_n, st_q, st_n, slot;
   logic [LW-1:0] ml_q, ml_n, el_q, el_n;
   logic [LINE_BITS-1:0] evd_q, evd_n, buf_q, buf_n, fill_data_n;
   logic [ADDRESS_SIZE-1:0] fill_addr_n, mem_addr_n;
   logic [BLOCK_SIZE-1:0] mem_wdata_n;
   logic accept, ack, wb_n, rd_n, miss_ready_n, fill_valid_n, mem_req_n, mem_we_n;
   logic unused_offsets;
   assign unused_offsets = ^{bus.evict_addr[OFFSET_LENGTH-1:0], bus.miss_addr[OFFSET_LENGTH-1:0]};
   always_comb begin
      accept = state == IDLE && bus.miss_valid && bus.miss_ready;
      ack = bus.mem_req && bus.mem_ack;
      slot = off_t'(k + st_q);
      state_n = state;
      k_n = k;
      st_n = st_q;
      ml_n = ml_q;
      el_n = el_q;
      evd_n = evd_q;
      buf_n = buf_q;
      case (state)
         IDLE: if (accept) begin
            state_n = bus.evict_dirty ? WB : FILL;
            k_n = '0;
            ml_n = bus.miss_addr[ADDRESS_SIZE-1:OFFSET_LENGTH];
            el_n = bus.evict_addr[ADDRESS_SIZE-1:OFFSET_LENGTH];
            evd_n = bus.evict_data;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
            st_n = bus.miss_addr[OFFSET_LENGTH-1:0];
`else
            st_n = '0;
`endif
         end
         WB: if (ack) begin
            k_n = k + 1'b1;
            state_n = &k ? FILL : WB;
         end
         FILL: if (ack) begin
            buf_n[slot*BLOCK_SIZE +: BLOCK_SIZE] = bus.mem_rdata;
            k_n = k + 1'b1;
            state_n = &k ? DONE : FILL;
         end
         DONE: state_n = IDLE;
      endcase
      // Bus outputs are registered: derive them from the next state so they hold between acks.
      wb_n = state_n == WB;
      rd_n = state_n == FILL;
      miss_ready_n = state_n == IDLE;
      fill_valid_n = state_n == DONE;
      mem_req_n = wb_n || rd_n;
      mem_we_n = mem_req_n ? wb_n : bus.mem_we;
      mem_addr_n = wb_n ? {el_n, k_n} : rd_n ? {ml_n, off_t'(k_n + st_n)} : bus.mem_addr;
      mem_wdata_n = wb_n ? evd_n[k_n*BLOCK_SIZE +: BLOCK_SIZE] : bus.mem_wdata;
      fill_addr_n = fill_valid_n ? {ml_n, {OFFSET_LENGTH{1'b0}}} : bus.fill_addr;
      fill_data_n = fill_valid_n ? buf_n : bus.fill_data;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         k <= '0;
         st_q <= '0;
         ml_q <= '0;
         el_q <= '0;
         evd_q <= '0;
         buf_q <= '0;
         bus.miss_ready <= 1'b0;
         bus.fill_valid <= 1'b0;
         bus.fill_addr <= '0;
         bus.fill_data <= '0;
         bus.mem_req <= 1'b0;
         bus.mem_we <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
      end else begin
         state <= state_n;
         k <= k_n;
         st_q <= st_n;
         ml_q <= ml_n;
         el_q <= el_n;
         evd_q <= evd_n;
         buf_q <= buf_n;
         bus.miss_ready <= miss_ready_n;
         bus.fill_valid <= fill_valid_n;
         bus.fill_addr <= fill_addr_n;
         bus.fill_data <= fill_data_n;
         bus.mem_req <= mem_req_n;
         bus.mem_we <= mem_we_n;
         bus.mem_addr <= mem_addr_n;
         bus.mem_wdata <= mem_wdata_n;
      end
endmodule

// File: tb/tb_cache_refill_unit.sv
// tb_cache_refill_unit: randomized refill traffic checked against a beat-list model of the refill protocol.
module tb_cache_refill_unit;
   localparam int BS = 32, N = 4, AS = 32, OL = $clog2(N), LB = BS * N;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
   localparam bit CRIT = 1'b1;
`else
   localparam bit CRIT = 1'b0;
`endif
   typedef struct packed {logic we; logic [AS-1:0] a; logic [BS-1:0] d;} beat_t;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, passed = 0;
   always #5 clk = ~clk;
   cache_refill_if #(.BLOCK_SIZE(BS), .NUM_OF_BLOCKS_PER_LINE(N), .ADDRESS_SIZE(AS)) bus ();
   cache_refill_unit #(.BLOCK_SIZE(BS), .NUM_OF_BLOCKS_PER_LINE(N), .ADDRESS_SIZE(AS)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask
   function automatic logic [BS-1:0] mem_fn(input logic [AS-1:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction
   // Called at a negedge; returns at the negedge where miss_ready should be back.
   task automatic run_miss(input bit dirty, input logic [AS-1:0] ea, input logic [LB-1:0] ed,
                           input logic [AS-1:0] ma, input int dmin, input int dmax, input bit hold);
      beat_t q[$];
      logic [AS-1:0] mb;
      logic [LB-1:0] line;
      int start, w, d;
      mb = {ma[AS-1:OL], OL'(0)};
      start = CRIT ? int'(ma % N) : 0;
      if (dirty) for (int i = 0; i < N; i++) q.push_back('{1'b1, {ea[AS-1:OL], OL'(i)}, ed[i*BS +: BS]});
      for (int i = 0; i < N; i++) q.push_back('{1'b0, {ma[AS-1:OL], OL'((start + i) % N)}, '0});
      for (int s = 0; s < N; s++) line[s*BS +: BS] = mem_fn(mb + s);
      w = 0;
      while (!bus.miss_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", bus.miss_ready, 1);
      bus.miss_valid = 1'b1;
      bus.evict_dirty = dirty;
      bus.evict_addr = ea;
      bus.evict_data = ed;
      bus.miss_addr = ma;
      @(posedge clk);
      @(negedge clk);
      bus.miss_valid = hold;
      if (hold) begin
         bus.evict_dirty = ~dirty;
         bus.evict_addr = $urandom;
         bus.evict_data = {$urandom, $urandom, $urandom, $urandom};
         bus.miss_addr = $urandom;
      end
      foreach (q[j]) begin
         d = $urandom_range(dmin, dmax);
         for (int t = 0; t <= d; t++) begin
            check("req", bus.mem_req, 1);
            check("we", bus.mem_we, q[j].we);
            check("addr", bus.mem_addr, q[j].a);
            if (q[j].we) check("wdata", bus.mem_wdata, q[j].d);
            check("busy_ready", bus.miss_ready, 0);
            check("early_fill", bus.fill_valid, 0);
            bus.mem_ack = (t == d);
            bus.mem_rdata = (t == d && !q[j].we) ? mem_fn(q[j].a) : BS'($urandom);
            @(negedge clk);
         end
      end
      bus.mem_ack = 1'($urandom_range(0, 1));
      check("fill_valid", bus.fill_valid, 1);
      check("fill_addr", bus.fill_addr, mb);
      check("fill_data", bus.fill_data, line);
      check("done_req", bus.mem_req, 0);
      check("done_ready", bus.miss_ready, 0);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("fill_pulse", bus.fill_valid, 0);
      check("ready_back", bus.miss_ready, 1);
      check("idle_req", bus.mem_req, 0);
      check("fill_hold", bus.fill_data, line);
   endtask
   initial begin
      bus.miss_valid = 1'b0;
      bus.evict_dirty = 1'b0;
      bus.evict_addr = '0;
      bus.evict_data = '0;
      bus.miss_addr = '0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", bus.miss_ready, 0);
      check("rst_fill_valid", bus.fill_valid, 0);
      check("rst_fill_addr", bus.fill_addr, 0);
      check("rst_fill_data", bus.fill_data, 0);
      check("rst_req", bus.mem_req, 0);
      check("rst_we", bus.mem_we, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      rst = 1'b0;
      check("ready_pre_edge", bus.miss_ready, 0);
      @(negedge clk);
      check("ready_post_rst", bus.miss_ready, 1);
      bus.mem_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stray_req", bus.mem_req, 0);
         check("stray_fill", bus.fill_valid, 0);
         check("stray_ready", bus.miss_ready, 1);
      end
      bus.mem_ack = 1'b0;
      run_miss(1'b0, 32'h0, '0, 32'h13, 0, 0, 1'b0);
      run_miss(1'b1, 32'h22, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 32'h40, 0, 0, 1'b0);
      run_miss(1'b0, 32'h0, '0, 32'h13, 2, 2, 1'b0);
      run_miss(1'b0, 32'h0, '0, 32'h12, 0, 0, 1'b0);
      // Reset in the middle of a fill: no pulse, ready one edge after release.
      bus.miss_valid = 1'b1;
      bus.evict_dirty = 1'b0;
      bus.miss_addr = 32'h80;
      @(posedge clk);
      @(negedge clk);
      bus.miss_valid = 1'b0;
      bus.mem_ack = 1'b1;
      repeat (2) begin
         bus.mem_rdata = $urandom;
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      check("pre_rst_req", bus.mem_req, 1);
      rst = 1'b1;
      #1;
      check("async_req", bus.mem_req, 0);
      check("async_fill", bus.fill_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      check("rel_ready", bus.miss_ready, 0);
      repeat (3) begin
         @(negedge clk);
         check("post_rst_ready", bus.miss_ready, 1);
         check("post_rst_fill", bus.fill_valid, 0);
         check("post_rst_req", bus.mem_req, 0);
      end
      run_miss(1'b0, 32'h0, '0, 32'h100, 0, 0, 1'b1);
      run_miss(1'b1, 32'h37, {$urandom, $urandom, $urandom, $urandom}, 32'h205, 0, 0, 1'b0);
      repeat (40)
         run_miss(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom},
                  $urandom, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      bus.miss_valid = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Memory-side miss engine for the direct-mapped cache. It accepts one line-miss request at a time, writes back the evicted line if it is dirty, then fetches the new line from backing memory one block per handshake. It returns the assembled line to the cache in a single-cycle fill pulse. It sits between the cache's miss port and the main-memory block interface. All addresses are block-granular: the low bits are the block offset, as in the cache.

## Interface
- BLOCK_SIZE, 32, bits per block
- NUM_OF_BLOCKS_PER_LINE, 4, blocks per line; power of two, ≥2
- ADDRESS_SIZE, 32, block-address width
- OFFSET_LENGTH, $clog2(NUM_OF_BLOCKS_PER_LINE), derived; do not override
- LINE_BITS, BLOCK_SIZE*NUM_OF_BLOCKS_PER_LINE, derived
- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  reset; asynchronous, active-high
- miss_valid  in  1  cache presents a miss
- miss_ready  out  1  unit idle, can accept
- miss_addr  in  ADDRESS_SIZE  missing block address; offset selects the critical block
- evict_dirty  in  1  victim line is dirty, sampled at accept
- evict_addr  in  ADDRESS_SIZE  victim line address; offset bits ignored
- evict_data  in  LINE_BITS  victim line; block k at bits [k*BLOCK_SIZE +: BLOCK_SIZE]
- fill_valid  out  1  one-cycle pulse, line ready
- fill_addr  out  ADDRESS_SIZE  line base (offset bits zero)
- fill_data  out  LINE_BITS  fetched line, same packing as evict_data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDRESS_SIZE  block address
- mem_wdata  out  BLOCK_SIZE  write data
- mem_ack  in  1  memory completes current block
- mem_rdata  in  BLOCK_SIZE  read data, valid with mem_ack on reads

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - miss_ready=1.
  - On miss_valid & miss_ready, capture miss_addr, evict_dirty, evict_addr and evict_data.
  - Go to WB if evict_dirty, else FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr={evict_addr line bits, k}, mem_wdata=block k.
  - k runs 0..N-1.
  - On mem_ack, k increments. After the ack for block N-1, go to FILL with k=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={miss line bits, slot}.
  - On mem_ack, store mem_rdata into the line buffer at that slot.
  - After the Nth ack, go to DONE.
- DONE:
  - fill_valid=1, fill_addr=line base, fill_data=buffer.
  - Next cycle go to IDLE.
- Slot order without the macro: 0,1,…,N-1.
- Offset counter is OFFSET_LENGTH bits and wraps modulo N.
- mem_req stays high across consecutive blocks. mem_addr, mem_we and mem_wdata change only on the cycle after an ack and are otherwise held stable.
- mem_ack while mem_req=0 is ignored.
- miss_valid outside IDLE is ignored; requests are not queued.
- fill_data/fill_addr retain their last values after DONE. They are meaningful only while fill_valid=1.

## Timing
- Reset values:
  - State IDLE, counter 0, buffer 0.
  - miss_ready=0, fill_valid=0, fill_addr=0, fill_data=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- miss_ready rises on the first clk edge after rst deasserts.
- All outputs are registered.
- Accept edge is T0. The first mem_req is visible after T0.
- With mem_ack high every cycle:
  - Clean miss: mem_req high T0+1..T0+N, fill_valid at T0+N+1, miss_ready at T0+N+2.
  - Dirty miss: adds N cycles.
- Each ack cycle completes exactly one block. Stalls (mem_ack low) add cycles 1:1.
- Reset asserted mid-transfer forces mem_req=0 and fill_valid=0 asynchronously. The partial line is discarded and no fill pulse is produced.

## Configuration
- CACHE_REFILL_CRITICAL_FIRST_EN defined:
  - FILL starts at slot miss_addr[OFFSET_LENGTH-1:0] and wraps modulo N, e.g. offset 2, N=4 gives 2,3,0,1.
  - Buffer slot placement remains by offset, so fill_data packing is unchanged.
  - WB order is always 0..N-1.
- Not defined: FILL always starts at slot 0.

## Test plan
- Clean miss, miss_addr=0x13, ack every cycle, rdata=0xA0+slot -> mem_addr reads 0x10,0x11,0x12,0x13; fill_valid at T0+5; fill_data={0xA3,0xA2,0xA1,0xA0}; fill_addr=0x10.
- Dirty miss, evict_addr=0x22, evict_data blocks {0xD3,0xD2,0xD1,0xD0}, miss_addr=0x40 -> writes 0x20..0x23 with wdata 0xD0..0xD3, then reads 0x40..0x43; fill_valid at T0+9.
- Clean miss with ack asserted 3 cycles after each request -> mem_addr/mem_req held stable while waiting; fill_valid at T0+13; data correct.
- Reset asserted after the 2nd FILL ack -> mem_req=0 immediately; no fill_valid; miss_ready=1 one edge after release; next miss completes normally.
- Macro defined, miss_addr=0x12 -> read order 0x12,0x13,0x10,0x11; fill_data identical to the macro-off result.
- miss_valid held high continuously with two requests -> second request accepted only at the miss_ready cycle (T0+6 for clean); stray mem_ack in IDLE has no effect.
